// File: rtl/sseg_rx.sv
// Oversampling receiver for the seven-segment shift-register stream.
// Deserialises each frame MSB-first into segs and flags frames abandoned mid-way.
module sseg_rx #(
  parameter int unsigned FRAME_BITS  = 64,
  parameter int unsigned IDLE_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seg_clk,
  input  logic                  seg_clrn,
  input  logic                  seg_sout,
  input  logic                  SEG_PEN,
  output logic [FRAME_BITS-1:0] segs,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  busy,
  output logic                  disp_en
);

  localparam int unsigned CntW  = $clog2(FRAME_BITS);
  localparam int unsigned IdleW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [CntW-1:0]  LastBit  = CntW'(FRAME_BITS - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  logic clk_s1, clk_s2, clk_s3;
  logic clrn_s1, clrn_s2;
  logic sout_s1, sout_s2;
  logic pen_s1, pen_s2;
  logic seg_edge;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdleW-1:0]      idle_q, idle_d;
  logic [FRAME_BITS-2:0] sr_q, sr_d;
  logic [FRAME_BITS-1:0] segs_q, segs_d;
  logic                  fv_q, fv_d;
  logic                  fe_q, fe_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1  <= 1'b0;
      clk_s2  <= 1'b0;
      clk_s3  <= 1'b0;
      clrn_s1 <= 1'b0;
      clrn_s2 <= 1'b0;
      sout_s1 <= 1'b0;
      sout_s2 <= 1'b0;
      pen_s1  <= 1'b0;
      pen_s2  <= 1'b0;
    end else begin
      clk_s1  <= seg_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      clrn_s1 <= seg_clrn;
      clrn_s2 <= clrn_s1;
      sout_s1 <= seg_sout;
      sout_s2 <= sout_s1;
      pen_s1  <= SEG_PEN;
      pen_s2  <= pen_s1;
    end
  end

  assign seg_edge = clk_s2 & ~clk_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idle_q  <= '0;
      sr_q    <= '0;
      segs_q  <= '0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      sr_q    <= sr_d;
      segs_q  <= segs_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    sr_d    = sr_q;
    segs_d  = segs_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    // Clear wins over a coincident edge or timeout and emits no pulse.
    if (!clrn_s2) begin
      state_d = StIdle;
      cnt_d   = '0;
      idle_d  = '0;
      sr_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          idle_d = '0;
          if (seg_edge) begin
            sr_d    = {sr_q[FRAME_BITS-3:0], sout_s2};
            cnt_d   = CntW'(1);
            state_d = StRecv;
          end
        end
        StRecv: begin
          if (seg_edge) begin
            idle_d = '0;
            if (cnt_q == LastBit) begin
              segs_d  = {sr_q, sout_s2};
              fv_d    = 1'b1;
              cnt_d   = '0;
              state_d = StIdle;
            end else begin
              sr_d  = {sr_q[FRAME_BITS-3:0], sout_s2};
              cnt_d = cnt_q + CntW'(1);
            end
          end else if (idle_q == IdleLast) begin
            fe_d    = 1'b1;
            cnt_d   = '0;
            idle_d  = '0;
            sr_d    = '0;
            state_d = StIdle;
          end else begin
            idle_d = idle_q + IdleW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign segs        = segs_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign busy        = (state_q == StRecv);
  assign disp_en     = pen_s2;

endmodule

// File: tb/tb_sseg_rx.sv
// Self-checking bench for sseg_rx: frame table plus hand-written corner sequences,
// with a scoreboard of expected frames popped on each frame_valid pulse.
module tb_sseg_rx;

  localparam int unsigned FB = 64;
  localparam int unsigned IC = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          seg_clk;
  logic          seg_clrn;
  logic          seg_sout;
  logic          seg_pen;
  logic [FB-1:0] segs;
  logic          frame_valid;
  logic          frame_err;
  logic          busy;
  logic          disp_en;

  sseg_rx #(
    .FRAME_BITS (FB),
    .IDLE_CYCLES(IC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_clk    (seg_clk),
    .seg_clrn   (seg_clrn),
    .seg_sout   (seg_sout),
    .SEG_PEN    (seg_pen),
    .segs       (segs),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .disp_en    (disp_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [63:0]   sb_q[$];
  int            fv_count = 0;
  int            err_count = 0;
  int            last_fv_cyc = 0;
  int            last_err_cyc = 0;
  int            rise_cyc = 0;
  logic          fv_prev = 1'b0;
  logic          fe_prev = 1'b0;

  typedef struct {
    logic [63:0] data;
    logic [63:0] exp_segs;
    logic        pen;
    logic        exp_disp;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: sample outputs mid-cycle.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_count++;
      last_fv_cyc = cyc;
      check("fv_pulse_width", {63'b0, fv_prev}, 64'd0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: got segs %h expected no frame", segs);
      end else begin
        check("sb_segs", segs, sb_q.pop_front());
      end
    end
    if (frame_err === 1'b1) begin
      err_count++;
      last_err_cyc = cyc;
      check("fe_pulse_width", {63'b0, fe_prev}, 64'd0);
    end
    fv_prev = frame_valid;
    fe_prev = frame_err;
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    seg_clk  = 1'b0;
    seg_sout = b;
    repeat (4) @(negedge clk);
    seg_clk  = 1'b1;
    rise_cyc = cyc;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(d[63-i]);
  endtask

  task automatic wait_fv(input int target, input string name);
    int budget = 40;
    while (fv_count < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(name, 64'(fv_count), 64'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_fv;
    int errs0;
    int budget;
    logic [63:0] segs_before;

    vecs[0] = '{64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D, 1'b1, 1'b1};
    vecs[1] = '{64'h0000000000000000, 64'h0000000000000000, 1'b0, 1'b0};
    vecs[2] = '{64'h3C3C_0FF0_9669_1248, 64'h3C3C_0FF0_9669_1248, 1'b1, 1'b1};

    rst      = 1'b1;
    seg_clk  = 1'b0;
    seg_clrn = 1'b1;
    seg_sout = 1'b0;
    seg_pen  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_segs", segs, 64'd0);
    check("rst_fv", {63'b0, frame_valid}, 64'd0);
    check("rst_fe", {63'b0, frame_err}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_disp", {63'b0, disp_en}, 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    exp_fv = 0;
    for (int v = 0; v < 3; v++) begin
      seg_pen = vecs[v].pen;
      sb_q.push_back(vecs[v].exp_segs);
      send_frame(vecs[v].data, 64);
      exp_fv++;
      wait_fv(exp_fv, "tbl_fv_count");
      check("tbl_segs", segs, vecs[v].exp_segs);
      check("tbl_disp", {63'b0, disp_en}, {63'b0, vecs[v].exp_disp});
      check("tbl_busy", {63'b0, busy}, 64'd0);
    end

    // Reset mid-frame
    send_frame(64'h5555555555555555, 30);
    check("mid_busy", {63'b0, busy}, 64'd1);
    @(negedge clk);
    seg_clk = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_segs", segs, 64'd0);
    check("arst_busy", {63'b0, busy}, 64'd0);
    check("arst_disp", {63'b0, disp_en}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    sb_q.push_back(64'h0123456789ABCDEF);
    send_frame(64'h0123456789ABCDEF, 64);
    exp_fv++;
    wait_fv(exp_fv, "post_rst_fv_count");

    // Bit order and latency
    sb_q.push_back(64'h8000000000000001);
    send_frame(64'h8000000000000001, 64);
    exp_fv++;
    wait_fv(exp_fv, "lat_fv_count");
    check("lat_cycles", 64'(last_fv_cyc - rise_cyc), 64'd3);
    check("lat_segs", segs, 64'h8000000000000001);

    // Truncation
    segs_before = segs;
    errs0 = err_count;
    send_frame(64'hFFFFFFFFFFFFFFFF, 10);
    @(negedge clk);
    seg_clk = 1'b0;
    budget = IC + 40;
    while (err_count == errs0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("trunc_err_count", 64'(err_count), 64'(errs0 + 1));
    check("trunc_err_cycles", 64'(last_err_cyc - rise_cyc), 64'(IC + 3));
    check("trunc_segs_kept", segs, segs_before);
    check("trunc_busy", {63'b0, busy}, 64'd0);
    check("trunc_no_fv", 64'(fv_count), 64'(exp_fv));
    sb_q.push_back(64'hFFFF0000FFFF0000);
    send_frame(64'hFFFF0000FFFF0000, 64);
    exp_fv++;
    wait_fv(exp_fv, "trunc_next_fv_count");

    // Clear mid-frame
    errs0 = err_count;
    segs_before = segs;
    send_frame(64'h0F0F0F0F0F0F0F0F, 20);
    check("clr_busy_before", {63'b0, busy}, 64'd1);
    @(negedge clk);
    seg_clrn = 1'b0;
    repeat (4) @(negedge clk);
    seg_clrn = 1'b1;
    repeat (3) @(negedge clk);
    check("clr_busy_after", {63'b0, busy}, 64'd0);
    repeat (IC + 10) @(negedge clk);
    check("clr_no_err", 64'(err_count), 64'(errs0));
    check("clr_segs_kept", segs, segs_before);
    sb_q.push_back(64'hA5A5A5A5A5A5A5A5);
    send_frame(64'hA5A5A5A5A5A5A5A5, 64);
    exp_fv++;
    wait_fv(exp_fv, "clr_next_fv_count");

    // Back-to-back frames
    sb_q.push_back(64'h1111111111111111);
    sb_q.push_back(64'h2222222222222222);
    send_frame(64'h1111111111111111, 64);
    send_frame(64'h2222222222222222, 64);
    exp_fv += 2;
    wait_fv(exp_fv, "b2b_fv_count");
    check("b2b_segs", segs, 64'h2222222222222222);

    // disp_en follows SEG_PEN two cycles later
    @(negedge clk);
    seg_pen = 1'b0;
    repeat (4) @(negedge clk);
    seg_pen = 1'b1;
    @(negedge clk);
    check("pen_lag1", {63'b0, disp_en}, 64'd0);
    @(negedge clk);
    check("pen_lag2", {63'b0, disp_en}, 64'd1);
    seg_pen = 1'b0;
    @(negedge clk);
    check("pen_fall_lag1", {63'b0, disp_en}, 64'd1);
    @(negedge clk);
    check("pen_fall_lag2", {63'b0, disp_en}, 64'd0);

    repeat (10) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("total_errs", 64'(err_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
